// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
// The optional requester lock is enabled with the UART_TX_SCHED_LOCK_EN macro.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } sched_state_e;

  localparam int DATA_W_DEFAULT = 8;
  localparam int NUM_REQ_MAX    = 8;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module uart_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + 32'(off)) % 32'(NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters,
// with a tx_done watchdog. Define UART_TX_SCHED_LOCK_EN to add req_lock.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  DATA_W         = DATA_W_DEFAULT,
  parameter int  TIMEOUT_CYCLES = 65536,
  localparam int IDX_W          = $clog2(NUM_REQ),
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  input  logic                      tx_active,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_err_q, timeout_err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] arb_req, arb_grant;
  logic [IDX_W-1:0]   arb_idx, next_ptr;
  logic               arb_any, hold_ptr;

  // tx_active is a status input only; it does not steer sequencing.
  logic unused_tx_active;
  assign unused_tx_active = tx_active;

`ifdef UART_TX_SCHED_LOCK_EN
  logic             lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic             lock_follow;

  // A held lock narrows eligibility to its owner only while the owner is still valid.
  assign lock_follow = lock_vld_q && req_valid[lock_id_q];
  assign arb_req     = lock_follow ? (NUM_REQ'(1) << lock_id_q) : req_valid;
  assign hold_ptr    = req_lock[arb_idx];

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (state_q == IDLE) begin
      if (lock_vld_q && !req_valid[lock_id_q]) lock_vld_d = 1'b0;
      if (arb_any) begin
        lock_vld_d = req_lock[arb_idx];
        lock_id_d  = arb_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  assign arb_req  = req_valid;
  assign hold_ptr = 1'b0;
`endif

  uart_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req      (arb_req),
    .rr_ptr   (rr_ptr_q),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .any_req  (arb_any)
  );

  assign next_ptr = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    req_ready     = '0;

    // Clear first so a timeout on the same edge overrides it.
    if (err_clr) timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = arb_grant;
        if (arb_any) begin
          tx_data_d  = req_data[arb_idx*DATA_W +: DATA_W];
          grant_id_d = arb_idx;
          if (!hold_ptr) rr_ptr_d = next_ptr;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (tx_done) begin
          state_d = IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=16).
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_active;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;
`ifdef UART_TX_SCHED_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ       (4),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
`ifdef UART_TX_SCHED_LOCK_EN
    .req_lock   (req_lock),
`endif
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_active  (tx_active),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  // Called on the START negedge; runs a 3-cycle frame and returns on the
  // negedge right after the tx_done edge (block back in IDLE).
  task automatic finish_frame();
    @(negedge clk);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %0h want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0h want 0", grant_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %0h want 0", timeout_err); end
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: got %0h want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 4'b0010;
    req_data  = 32'h0000_A500;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %0h want 2", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_tx_start: got %0h want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data: got %0h want a5", tx_data); end
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL single_grant_id: got %0h want 1", grant_id); end
    @(negedge clk);
    n_cmp++; if ({tx_start, busy} !== 2'b01) begin n_err++; $display("FAIL single_busy: got %0h want 1", {tx_start, busy}); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %0h want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    pulse_reset();
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_first_ready: got %0h want 1", req_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL rr_start%0d: got %0h want 1", k, tx_start); end
      n_cmp++; if (grant_id !== 2'(k % 4)) begin n_err++; $display("FAIL rr_grant%0d: got %0h want %0h", k, grant_id, k % 4); end
      n_cmp++; if (tx_data !== 8'(8'h10 + k % 4)) begin n_err++; $display("FAIL rr_data%0d: got %0h want %0h", k, tx_data, 8'h10 + k % 4); end
      if (k == 4) req_valid = 4'b0000;
      @(negedge clk);
      n_cmp++; if ({tx_start, req_ready} !== 5'b0) begin n_err++; $display("FAIL rr_hold%0d: got %0h want 0", k, {tx_start, req_ready}); end
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      exp_rdy = (k < 4) ? 4'(1 << ((k + 1) % 4)) : 4'h0;
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready%0d: got %0h want %0h", k, req_ready, exp_rdy); end
    end
  endtask

  task automatic test_timeout();
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    @(negedge clk);
    req_valid = 4'b0000;
    n_cmp++; if ({tx_start, tx_data} !== 9'h13C) begin n_err++; $display("FAIL to_start: got %0h want 13c", {tx_start, tx_data}); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++; if ({busy, timeout_err} !== 2'b10) begin n_err++; $display("FAIL to_wait%0d: got %0h want 2", i, {busy, timeout_err}); end
    end
    @(negedge clk);
    n_cmp++; if ({busy, timeout_err} !== 2'b01) begin n_err++; $display("FAIL to_fire: got %0h want 1", {busy, timeout_err}); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %0h want 0", timeout_err); end
  endtask

  task automatic test_done_at_timeout();
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (16) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    n_cmp++; if ({busy, timeout_err} !== 2'b00) begin n_err++; $display("FAIL done_vs_timeout: got %0h want 0", {busy, timeout_err}); end
  endtask

  task automatic test_set_wins();
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (16) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL set_over_clr: got %0h want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    req_data  = 32'h7700_0000;
    @(negedge clk);
    req_valid = 4'b0000;
    n_cmp++; if ({grant_id, tx_data} !== 10'h377) begin n_err++; $display("FAIL rm_grant: got %0h want 377", {grant_id, tx_data}); end
    @(negedge clk);
    n_cmp++; if ({busy, timeout_err} !== 2'b11) begin n_err++; $display("FAIL rm_pre: got %0h want 3", {busy, timeout_err}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({tx_start, busy, timeout_err} !== 3'b000) begin n_err++; $display("FAIL rm_ctrl: got %0h want 0", {tx_start, busy, timeout_err}); end
    n_cmp++; if ({grant_id, tx_data} !== 10'h000) begin n_err++; $display("FAIL rm_data: got %0h want 0", {grant_id, tx_data}); end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rm_ready: got %0h want 1", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_cmp++; if ({tx_start, grant_id, tx_data} !== 11'h411) begin n_err++; $display("FAIL rm_regrant: got %0h want 411", {tx_start, grant_id, tx_data}); end
    finish_frame();
  endtask

`ifdef UART_TX_SCHED_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_id [5];
    logic [7:0] exp_b  [5];
    exp_id = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    exp_b  = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hA0};
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0000;
    finish_frame();
    req_valid = 4'b1101;
    req_data  = 32'hD0C0_00A0;
    req_lock  = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL lock_ready: got %0h want 4", req_ready); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++; if ({grant_id, tx_data} !== {exp_id[j], exp_b[j]}) begin n_err++; $display("FAIL lock_seq%0d: got %0h want %0h", j, {grant_id, tx_data}, {exp_id[j], exp_b[j]}); end
      case (j)
        0: begin req_data[23:16] = 8'hC1; req_lock[2] = 1'b1; end
        1: begin req_data[23:16] = 8'hC2; req_lock[2] = 1'b0; end
        2: req_valid[2] = 1'b0;
        3: req_valid[3] = 1'b0;
        default: req_valid[0] = 1'b0;
      endcase
      finish_frame();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_done   = 1'b0;
    tx_active = 1'b0;
    err_clr   = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
    req_lock  = 4'b0000;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_set_wins();
    test_reset_mid();
`ifdef UART_TX_SCHED_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmitter among NUM_REQ byte-producing requesters using round-robin arbitration. Each accepted byte is sequenced into the transmitter: a one-cycle tx_start pulse, then a wait for tx_done. A watchdog on tx_done recovers the block from a hung transmitter. Sits between the requester clients and the UART TX datapath, driving its tx_start/tx_data and observing tx_done/tx_active.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width (matches UART tx_data)
TIMEOUT_CYCLES, 65536, clk cycles allowed in BUSY before a timeout is declared (min 16)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot combinational accept; a byte transfers on valid&ready at the clock edge
tx_start  output  1  registered one-cycle start pulse to the UART TX
tx_data  output  DATA_W  registered byte to the UART TX, held stable from START through BUSY
tx_done  input  1  UART TX frame-complete pulse
tx_active  input  1  UART TX busy indication (status only)
grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester
busy  output  1  high in START or BUSY
timeout_err  output  1  sticky watchdog flag
err_clr  input  1  clears timeout_err

Behaviour:
- Reset values: state=IDLE, tx_start=0, tx_data=0, grant_id=0, rr_ptr=0, timeout_err=0, timer=0. req_ready=0 outside IDLE.
- FSM states: IDLE, START, BUSY.
- IDLE:
  - Pick the first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Drive req_ready for that requester only.
  - On the edge: latch tx_data from the picked requester, set grant_id to its index, set rr_ptr to pick+1 (wrapping), go to START.
  - No valid requester: stay in IDLE, all req_ready=0.
- START: tx_start=1 for exactly this one cycle; clear timer; go to BUSY.
- BUSY:
  - tx_done=1: go to IDLE.
  - Otherwise increment timer. When timer reaches TIMEOUT_CYCLES-1: set timeout_err and go to IDLE. The byte is dropped, with no retry.
- Latency: handshake edge N, tx_start high in cycle N+1. After tx_done at edge M, the next req_ready can be asserted in cycle M+1. Minimum byte-to-byte spacing is therefore (frame length + 2) cycles.
- tx_done outside BUSY is ignored.
- tx_done and timeout on the same edge: tx_done wins, timeout_err is not set.
- err_clr and a new timeout on the same edge: set wins.
- req_valid dropped before it is granted: no effect; the byte is simply not taken.
- tx_active is not used for sequencing; it is exposed for assertions only.
- Async reset mid-operation: all state returns to reset values immediately, tx_start deasserts, and the in-flight byte is lost.
- Timer width: $clog2(TIMEOUT_CYCLES); it must not wrap before the compare.

Optional Feature:
UART_TX_SCHED_LOCK_EN
- Defined:
  - Adds input req_lock [NUM_REQ].
  - If the granted requester has req_lock=1 at the handshake edge, rr_ptr is not advanced.
  - While the locked requester's req_valid=1 in IDLE, only it is eligible. This keeps multi-byte messages contiguous.
  - The lock releases when that requester is granted with req_lock=0, or is idle with req_valid=0 in IDLE.
- Undefined: no req_lock port; pure round-robin.

Decomposition:
- Package uart_sched_pkg holds:
  - sched_state_e enum {IDLE, START, BUSY}
  - DATA_W default constant
  - NUM_REQ_MAX=8
- Sub-module uart_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_req.

Test Plan:
- Single requester: req1 valid with 0xA5 → req_ready[1] in the same cycle; tx_start one cycle later with tx_data=0xA5; grant_id=1; tx_done returns the block to IDLE.
- All four requesters continuously valid with bytes 0x10..0x13 and rr_ptr=0 → grant order 0,1,2,3,0; each byte's tx_start appears only after the previous tx_done.
- Hung TX with TIMEOUT_CYCLES=16 and no tx_done → timeout_err=1 on the 16th BUSY edge and state returns to IDLE; err_clr pulse → timeout_err=0.
- tx_done on the same edge as the timeout → timeout_err stays 0.
- rst asserted in BUSY → tx_start, busy, timeout_err and grant_id all 0 immediately; after release, the next grant starts from requester 0.
- With UART_TX_SCHED_LOCK_EN: req2 sends 3 bytes with req_lock=1,1,0 while req0 and req3 are valid → the bytes go out 2,2,2, then 3, then 0.
